// File: rtl/vram_access_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_access_arbiter_if : CPU, display-fetch and RAM-pin signal bundle      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface vram_access_arbiter_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 8
);
   logic                  cpu_req;
   logic                  cpu_write;
   logic [ADDR_WIDTH-1:0] cpu_address;
   logic [DATA_WIDTH-1:0] cpu_data_in;
   logic [DATA_WIDTH-1:0] cpu_data_out;
   logic                  VIDEO_READY;
   logic                  disp_req;
   logic [ADDR_WIDTH-1:0] disp_address;
   logic [DATA_WIDTH-1:0] disp_data;
   logic                  disp_ack;
   logic [ADDR_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0] ram_data_out;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic                  ram_we;
   logic                  ram_oe;

   modport slave (
      input  cpu_req, cpu_write, cpu_address, cpu_data_in,
      input  disp_req, disp_address, ram_data_in,
      output cpu_data_out, VIDEO_READY, disp_data, disp_ack,
      output ram_address, ram_data_out, ram_we, ram_oe
   );

   modport master (
      output cpu_req, cpu_write, cpu_address, cpu_data_in,
      output disp_req, disp_address, ram_data_in,
      input  cpu_data_out, VIDEO_READY, disp_data, disp_ack,
      input  ram_address, ram_data_out, ram_we, ram_oe
   );
endinterface
`default_nettype wire

// File: rtl/vram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_access_arbiter : shares one VRAM port between CPU and display fetch   |
// | Optional CPU fairness flag under `VRAM_CPU_FAIRNESS_EN.  Rev 1.0           |
// +----------------------------------------------------------------------------+
module vram_access_arbiter #(
   parameter int ADDR_WIDTH    = 17,
   parameter int DATA_WIDTH    = 8,
   parameter int ACCESS_CYCLES = 4
) (
   input  wire logic             clock,
   input  wire logic             reset_n,
   vram_access_arbiter_if.slave  bus
);
   localparam int                   CNT_WIDTH   = $clog2(ACCESS_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(ACCESS_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_WE_LAST = CNT_WIDTH'(ACCESS_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DISP = 2'd1,
      ST_CPU  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  counter_q, counter_d;
   logic                  disp_pending_q, disp_pending_d;
   logic [ADDR_WIDTH-1:0] disp_addr_q, disp_addr_d;
   logic                  cpu_seen_q, cpu_seen_d;
   logic                  cpu_started_q, cpu_started_d;
   logic                  cpu_done_q, cpu_done_d;
   logic                  cpu_write_q, cpu_write_d;
   logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0] ram_data_out_q, ram_data_out_d;
   logic                  ram_we_q, ram_we_d;
   logic                  ram_oe_q, ram_oe_d;
   logic [DATA_WIDTH-1:0] cpu_data_out_q, cpu_data_out_d;
   logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
   logic                  disp_ack_q, disp_ack_d;
   logic                  cpu_pending;
   logic                  cpu_first;

   // The CPU strobe is qualified by its registered copy so that a display pulse
   // arriving in the same cycle is already pending when the CPU is first seen.
   assign cpu_pending = bus.cpu_req & cpu_seen_q & ~cpu_started_q;

`ifdef VRAM_CPU_FAIRNESS_EN
   logic cpu_priority_q, cpu_priority_d;
   assign cpu_first = cpu_priority_q & cpu_pending;
`else
   assign cpu_first = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      counter_d      = counter_q;
      disp_pending_d = disp_pending_q;
      disp_addr_d    = disp_addr_q;
      cpu_seen_d     = bus.cpu_req;
      cpu_started_d  = cpu_started_q;
      cpu_done_d     = cpu_done_q;
      cpu_write_d    = cpu_write_q;
      ram_address_d  = ram_address_q;
      ram_data_out_d = '0;
      ram_we_d       = 1'b0;
      ram_oe_d       = 1'b0;
      cpu_data_out_d = cpu_data_out_q;
      disp_data_d    = disp_data_q;
      disp_ack_d     = 1'b0;
`ifdef VRAM_CPU_FAIRNESS_EN
      cpu_priority_d = cpu_priority_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (disp_pending_q && !cpu_first) begin
               state_d        = ST_DISP;
               counter_d      = '0;
               disp_pending_d = 1'b0;
               ram_address_d  = disp_addr_q;
               ram_oe_d       = 1'b1;
            end else if (cpu_pending) begin
               state_d        = ST_CPU;
               counter_d      = '0;
               cpu_started_d  = 1'b1;
               cpu_write_d    = bus.cpu_write;
               ram_address_d  = bus.cpu_address;
               ram_data_out_d = bus.cpu_data_in;
               ram_we_d       = bus.cpu_write;
               ram_oe_d       = ~bus.cpu_write;
`ifdef VRAM_CPU_FAIRNESS_EN
               cpu_priority_d = 1'b0;
`endif
            end
         end
         ST_DISP: begin
            if (counter_q == CNT_LAST) begin
               state_d     = ST_IDLE;
               counter_d   = '0;
               disp_data_d = bus.ram_data_in;
               disp_ack_d  = 1'b1;
`ifdef VRAM_CPU_FAIRNESS_EN
               if (cpu_pending) cpu_priority_d = 1'b1;
`endif
            end else begin
               counter_d = counter_q + 1'b1;
               ram_oe_d  = 1'b1;
            end
         end
         ST_CPU: begin
            if (counter_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               counter_d = '0;
               if (!cpu_write_q) cpu_data_out_d = bus.ram_data_in;
               if (bus.cpu_req)  cpu_done_d     = 1'b1;
            end else begin
               counter_d      = counter_q + 1'b1;
               ram_data_out_d = ram_data_out_q;
               ram_oe_d       = ~cpu_write_q;
               // WE drops one cycle before the end to give the RAM data hold time.
               ram_we_d       = cpu_write_q && (counter_q < CNT_WE_LAST);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus.disp_req) begin
         disp_pending_d = 1'b1;
         disp_addr_d    = bus.disp_address;
      end
      if (!bus.cpu_req) begin
         cpu_started_d = 1'b0;
         cpu_done_d    = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         counter_q      <= '0;
         disp_pending_q <= 1'b0;
         disp_addr_q    <= '0;
         cpu_seen_q     <= 1'b0;
         cpu_started_q  <= 1'b0;
         cpu_done_q     <= 1'b0;
         cpu_write_q    <= 1'b0;
         ram_address_q  <= '0;
         ram_data_out_q <= '0;
         ram_we_q       <= 1'b0;
         ram_oe_q       <= 1'b0;
         cpu_data_out_q <= '0;
         disp_data_q    <= '0;
         disp_ack_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         counter_q      <= counter_d;
         disp_pending_q <= disp_pending_d;
         disp_addr_q    <= disp_addr_d;
         cpu_seen_q     <= cpu_seen_d;
         cpu_started_q  <= cpu_started_d;
         cpu_done_q     <= cpu_done_d;
         cpu_write_q    <= cpu_write_d;
         ram_address_q  <= ram_address_d;
         ram_data_out_q <= ram_data_out_d;
         ram_we_q       <= ram_we_d;
         ram_oe_q       <= ram_oe_d;
         cpu_data_out_q <= cpu_data_out_d;
         disp_data_q    <= disp_data_d;
         disp_ack_q     <= disp_ack_d;
      end
   end

`ifdef VRAM_CPU_FAIRNESS_EN
   always_ff @(posedge clock) begin
      if (!reset_n) cpu_priority_q <= 1'b0;
      else          cpu_priority_q <= cpu_priority_d;
   end
`endif

   assign bus.VIDEO_READY  = ~bus.cpu_req | cpu_done_q;
   assign bus.cpu_data_out = cpu_data_out_q;
   assign bus.disp_data    = disp_data_q;
   assign bus.disp_ack     = disp_ack_q;
   assign bus.ram_address  = ram_address_q;
   assign bus.ram_data_out = ram_data_out_q;
   assign bus.ram_we       = ram_we_q;
   assign bus.ram_oe       = ram_oe_q;
endmodule
`default_nettype wire
